// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SERIAL_ADDER_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFin   = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell, start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADDER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;
  logic load;

  full_adder_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    load    = 1'b0;

    unique case (state_q)
      StIdle: load = start;
      StShift: begin
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        psum_d            = psum_q >> 1;
        psum_d[WIDTH-1]   = fa_s;
        carry_d           = fa_co;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StFin;
          sum_d   = psum_d;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on the last shift cycle
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      StFin: begin
        if (start) begin
          load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StShift;
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      psum_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StFin);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned {cout,sum} = a+b+cin; ovf when the signed result leaves the 8-bit range.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       output logic [W-1:0] ms, output logic mc, output logic mo);
    int unsigned u;
    int s;
    u  = int'(ta) + int'(tb_) + int'(tc);
    s  = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
    ms = W'(u);
    mc = (u >= 256);
    mo = (s > 127) || (s < -128);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_lo"}, busy, 0);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, exp_ovf);
`endif
  endtask

  // One operation from IDLE; glitch_at (1..W-1) pulses start with zero operands during SHIFT.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input int glitch_at);
    logic [W-1:0] ms;
    logic         mc, mo;
    int           d0;
    model(ta, tb_, tc, ms, mc, mo);
    d0 = done_cnt;
    a = ta; b = tb_; cin = tc; start = 1'b1;
    step();
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 1; i <= int'(W); i++) begin
      check("op_busy", busy, 1);
      check("op_done_lo", done, 0);
      check("op_sum_hold", sum, exp_sum);
      if (i == glitch_at) begin
        start = 1'b1; a = '0; b = '0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    exp_sum = ms; exp_cout = mc; exp_ovf = mo;
    check_result("op");
    step();
    check("op_after_done", done, 0);
    check("op_after_busy", busy, 0);
    check("op_one_done", done_cnt - d0, 1);
  endtask

  initial begin
    logic [W-1:0] ba [4];
    logic [W-1:0] bb [4];
    logic         bc [4];
    logic [W-1:0] ms;
    logic         mc, mo;
    int           d0;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    // rst and start together: reset wins
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    step();
    check("rst_start_busy", busy, 0);
    check("rst_start_done", done, 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("idle_busy", busy, 0);

    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h55, 8'hAA, 1'b1, 0);
    do_op(8'h12, 8'h34, 1'b0, 3);

    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      step();
      check("idle_sum_hold", sum, 8'h46);
      check("idle_busy_lo", busy, 0);
    end

    do_op(8'h7F, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    // Reset mid-operation
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    d0 = done_cnt;
    step();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    rst = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", busy, 0);

    // Back-to-back with start held high
    for (int k = 0; k < 4; k++) begin
      ba[k] = W'($urandom); bb[k] = W'($urandom); bc[k] = 1'($urandom);
    end
    d0 = done_cnt;
    a = ba[0]; b = bb[0]; cin = bc[0]; start = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      model(ba[k], bb[k], bc[k], ms, mc, mo);
      if (k < 3) begin
        a = ba[k+1]; b = bb[k+1]; cin = bc[k+1];
      end
      for (int i = 1; i <= int'(W); i++) begin
        check("b2b_busy", busy, 1);
        check("b2b_done_lo", done, 0);
        check("b2b_sum_hold", sum, exp_sum);
        step();
      end
      exp_sum = ms; exp_cout = mc; exp_ovf = mo;
      check_result("b2b");
      if (k == 3) start = 1'b0;
      step();
    end
    check("b2b_end_busy", busy, 0);
    check("b2b_done_count", done_cnt - d0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single 1-bit full-adder cell. Each clock cycle it adds one bit pair, LSB first, and keeps the carry in a flip-flop between cycles. It sits directly downstream of the 1-bit full adder: it instantiates that cell and turns it into a multi-cycle, start/done-handshaked arithmetic unit. This lets the lab datapath add WIDTH-bit operands with one adder cell.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range ≥ 1.

Ports:
- clk, in, 1: sole clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request to add; sampled only when the block is ready to accept.
- a, in, WIDTH: operand A, captured on an accepted start.
- b, in, WIDTH: operand B, captured on an accepted start.
- cin, in, 1: carry-in, captured on an accepted start.
- busy, out, 1: high while bits are being processed.
- done, out, 1: one-cycle pulse when the result registers update.
- sum, out, WIDTH: result, held until the next completion.
- cout, out, 1: final carry-out, held with sum.

## Operation
- FSM states: IDLE, SHIFT, FIN.
- Reset state is IDLE.
- IDLE, start=1: load shift registers a_sh←a, b_sh←b, load carry←cin, clear the partial-sum register and bit counter, go to SHIFT.
- SHIFT, each cycle:
  - The full-adder cell takes a_sh[0], b_sh[0] and carry.
  - Its sum bit enters the MSB of the partial-sum register, which shifts right.
  - a_sh and b_sh shift right; carry takes the cell's carry-out; the counter increments.
  - After WIDTH SHIFT cycles, go to FIN.
- SHIFT→FIN edge: copy the partial sum to the sum output and the final carry to cout.
- FIN: done=1 for one cycle.
  - start=1 in FIN is accepted exactly as in IDLE and goes straight to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- start while in SHIFT is ignored; operands are not re-sampled.
- Arithmetic is unsigned: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH+1).
- WIDTH=1 is legal: exactly one SHIFT cycle.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0; internal shift registers, carry and counter are 0.
- If start is accepted at edge E0:
  - busy=1 in cycles E0+1 … E0+WIDTH.
  - done=1 and sum/cout valid in cycle E0+WIDTH+1.
  - Latency from accepted start to done is WIDTH+1 cycles.
- Back-to-back: the throughput period is WIDTH+1 cycles.
  - In the FIN cycle where start is accepted, done=1 and busy=0.
  - busy rises on the next cycle.
- sum/cout change only on the SHIFT→FIN edge and on reset. They stay stable throughout IDLE and during a following operation's SHIFT cycles.
- rst asserted mid-operation: next cycle is IDLE with all outputs at reset values. No done pulse is produced for the aborted operation.
- rst and start together: rst wins.

## Configuration
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1): signed two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB.
  - ovf is captured on the same edge as sum, reset to 0, and held with sum.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package serial_adder_pkg holds:
  - The state typedef (IDLE/SHIFT/FIN enum, 2 bits).
  - The default width constant SERIAL_ADDER_W = 8.
- One sub-module: full_adder_bit, a purely combinational cell with ports (a, b, ci) → (s, co). It is instantiated once.
- The top level holds the FSM, shift registers, carry flip-flop, counter and output registers.

## Test plan
- WIDTH=8; a=8'hFF, b=8'h01, cin=0; start at E0 → done at E0+9; sum=8'h00, cout=1; busy high for exactly 8 cycles.
- a=8'h55, b=8'hAA, cin=1 → sum=8'h00, cout=1. Then a=8'h12, b=8'h34, cin=0 → sum=8'h46, cout=0.
- Pulse start again with a=8'h00 at E0+3 (while busy) → ignored; first result 8'h46 is still produced at E0+9; exactly one done pulse.
- Assert rst at E0+4 → busy=0, sum=0 at E0+5; no done pulse afterwards.
- Back-to-back: start held high continuously → done pulses every 9 cycles; sums match the reference model each time.
- With SERIAL_ADDER_OVF_EN defined: a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'hFF, b=8'h01 → ovf=0.
